// File: rtl/ili9341_spi_receiver_if.sv
// 4-wire ILI9341 SPI bus as seen at the panel: the host drives it, the receiver samples it.
interface ili9341_spi_receiver_if;
    logic spi_sck;
    logic spi_mosi;
    logic spi_cs;
    logic spi_dc;

    modport master (output spi_sck, spi_mosi, spi_cs, spi_dc);
    modport slave  (input  spi_sck, spi_mosi, spi_cs, spi_dc);
endinterface

// File: rtl/ili9341_spi_receiver.sv
// Panel-side ILI9341 SPI receiver: oversamples the bus, decodes CASET/PASET/RAMWR/RAMWRC
// and emits RGB565 pixels with their coordinates inside the programmed address window.
module ili9341_spi_receiver #(
    parameter int unsigned H_RES   = 240,
    parameter int unsigned V_RES   = 320,
    parameter int unsigned COORD_W = 9
) (
    input  logic                         clk_out,
    input  logic                         rst,
    ili9341_spi_receiver_if.slave        spi,
    output logic                         pix_valid,
    output logic [15:0]                  pix_data,
    output logic [COORD_W-1:0]           pix_x,
    output logic [COORD_W-1:0]           pix_y,
    output logic                         frame_done,
    output logic                         cmd_valid,
    output logic [7:0]                   cmd_byte,
    output logic                         busy
);
    typedef enum logic [2:0] {StIdle, StCaset, StPaset, StRamwr, StIgnore} state_e;

    localparam logic [15:0] XMax    = 16'(H_RES - 1);
    localparam logic [15:0] YMax    = 16'(V_RES - 1);
    // Synchronizer reset pattern {dc, cs, mosi, sck}: cs idles high so busy reads 0.
    localparam logic [3:0]  SyncRst = 4'b0100;

    logic [3:0] sync1_q, sync2_q;
    logic       sck_prev_q, cs_prev_q;
    logic       sck_s, mosi_s, cs_s, dc_s, sck_rise, cs_rise;

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            sync1_q    <= SyncRst;
            sync2_q    <= SyncRst;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            sync1_q    <= {spi.spi_dc, spi.spi_cs, spi.spi_mosi, spi.spi_sck};
            sync2_q    <= sync1_q;
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_s;
        end
    end

    assign {dc_s, cs_s, mosi_s, sck_s} = sync2_q;
    assign sck_rise = sck_s & ~sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign busy     = ~cs_s;

    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_q;
    logic       byte_dc_q, byte_stb_q;

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_q     <= '0;
            byte_dc_q  <= 1'b0;
            byte_stb_q <= 1'b0;
        end else begin
            byte_stb_q <= 1'b0;
            if (cs_rise) begin
                bit_cnt_q <= '0;
            end else if (sck_rise && !cs_s) begin
                shift_q   <= {shift_q[5:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_q     <= {shift_q, mosi_s};
                    byte_dc_q  <= dc_s;
                    byte_stb_q <= 1'b1;
                end
            end
        end
    end

    state_e             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, hi_byte_q, hi_byte_d;
    logic               hi_pend_q, hi_pend_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic               pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_byte_q, cmd_byte_d;

    // Window clamp: start = min(v, max); end = min(max(v, start), max).
    logic [15:0]        lim, start_raw, end_raw, end_m;
    logic [COORD_W-1:0] start_c, end_c;

    assign lim       = (state_q == StCaset) ? XMax : YMax;
    assign start_raw = {p0_q, p1_q};
    assign end_raw   = {p2_q, byte_q};
    assign start_c   = (start_raw > lim) ? lim[COORD_W-1:0] : start_raw[COORD_W-1:0];
    assign end_m     = (end_raw < 16'(start_c)) ? 16'(start_c) : end_raw;
    assign end_c     = (end_m > lim) ? lim[COORD_W-1:0] : end_m[COORD_W-1:0];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        hi_byte_d    = hi_byte_q;
        hi_pend_d    = hi_pend_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;

        if (byte_stb_q && !byte_dc_q) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = byte_q;
            idx_d       = '0;
            hi_pend_d   = 1'b0;
            case (byte_q)
                8'h2A: state_d = StCaset;
                8'h2B: state_d = StPaset;
                8'h2C: begin
                    state_d = StRamwr;
                    x_d     = xs_q;
                    y_d     = ys_q;
                end
                8'h3C: state_d = StRamwr;
                8'h00: state_d = StIdle;
                default: state_d = StIgnore;
            endcase
        end else if (byte_stb_q) begin
            case (state_q)
                StCaset, StPaset: begin
                    idx_d = idx_q + 2'd1;
                    unique case (idx_q)
                        2'd0: p0_d = byte_q;
                        2'd1: p1_d = byte_q;
                        2'd2: p2_d = byte_q;
                        2'd3: begin
                            state_d = StIdle;
                            if (state_q == StCaset) begin
                                xs_d = start_c;
                                xe_d = end_c;
                            end else begin
                                ys_d = start_c;
                                ye_d = end_c;
                            end
                        end
                    endcase
                end
                StRamwr: begin
                    if (!hi_pend_q) begin
                        hi_byte_d = byte_q;
                        hi_pend_d = 1'b1;
                    end else begin
                        hi_pend_d   = 1'b0;
                        pix_valid_d = 1'b1;
                        pix_data_d  = {hi_byte_q, byte_q};
                        pix_x_d     = x_q;
                        pix_y_d     = y_q;
                        if (x_q < xe_q) begin
                            x_d = x_q + 1'b1;
                        end else if (y_q < ye_q) begin
                            x_d = xs_q;
                            y_d = y_q + 1'b1;
                        end else begin
                            frame_done_d = 1'b1;
                            x_d          = xs_q;
                            y_d          = ys_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            p0_q         <= '0;
            p1_q         <= '0;
            p2_q         <= '0;
            hi_byte_q    <= '0;
            hi_pend_q    <= 1'b0;
            xs_q         <= '0;
            xe_q         <= XMax[COORD_W-1:0];
            ys_q         <= '0;
            ye_q         <= YMax[COORD_W-1:0];
            x_q          <= '0;
            y_q          <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            hi_byte_q    <= hi_byte_d;
            hi_pend_q    <= hi_pend_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
        end
    end

    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign frame_done = frame_done_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
endmodule
